// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback path.
package rf_pkg;
    localparam int   NREG    = 32;
    localparam int   AW      = $clog2(NREG);
    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_MEM = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is ALU, bit 1 is MEM.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == GNT_MEM) ? 2'b01 : 2'b10;
        end
    end

    // Only a completed transfer moves the priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_MEM;
        end else if (advance) begin
            last_grant <= gnt[1] ? GNT_MEM : GNT_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto the single register-file write port
// and tracks in-flight destinations to stall hazardous issues.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_wr,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] issue_rs1,
    input  logic [AW-1:0] issue_rs2,
    output logic          issue_stall,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [N-1:0]  alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [N-1:0]  mem_data,
    output logic          mem_ready,
    output logic          regWrite,
    output logic [AW-1:0] wr_rd,
    output logic [N-1:0]  wr_data,
    output logic          wb_err
);

    logic [1:0]      gnt;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [N-1:0]    sel_data;
    logic            issue_fire;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({mem_valid, alu_valid}),
        .advance (xfer),
        .gnt     (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign xfer      = |gnt;

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (gnt[1]) begin
            sel_rd   = mem_rd;
            sel_data = mem_data;
        end
    end

    // No bypass: a write landing this cycle still stalls its readers.
    assign issue_stall = issue_valid &
                         (pending[issue_rs1] | pending[issue_rs2] |
                          (issue_wr & pending[issue_rd]));
    assign issue_fire  = issue_valid & issue_wr & ~issue_stall & (issue_rd != '0);

    always_comb begin
        pending_nxt = pending;
        if (regWrite) begin
            pending_nxt[wr_rd] = 1'b0;
        end
        if (issue_fire) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // x0 transfers are acknowledged but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite <= 1'b0;
            wr_rd    <= '0;
            wr_data  <= '0;
        end else begin
            regWrite <= xfer && (sel_rd != '0);
            if (xfer && (sel_rd != '0)) begin
                wr_rd   <= sel_rd;
                wr_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (xfer && (sel_rd != '0) && !pending[sel_rd]) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table, reset-mid-op sequence, then randomized traffic
// against a scoreboard-style reference model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0, issue_wr = 1'b0;
    logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic        issue_stall;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        regWrite;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.N(32), .NREG(32), .AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .regWrite    (regWrite),
        .wr_rd       (wr_rd),
        .wr_data     (wr_data),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, iw;
        logic [4:0]  ird, irs1, irs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        st, ar, mr, rw;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        err;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic [31:0] iv, iw, ird, irs1, irs2,
        input logic [31:0] av, ard, adata, mv, mrd, mdata,
        input logic [31:0] st, ar, mr, rw, wrd, wdata, err);
        vec_t v;
        v.iv = iv[0];    v.iw = iw[0];
        v.ird = ird[4:0]; v.irs1 = irs1[4:0]; v.irs2 = irs2[4:0];
        v.av = av[0];    v.ard = ard[4:0]; v.adata = adata;
        v.mv = mv[0];    v.mrd = mrd[4:0]; v.mdata = mdata;
        v.st = st[0];    v.ar = ar[0]; v.mr = mr[0]; v.rw = rw[0];
        v.wrd = wrd[4:0]; v.wdata = wdata; v.err = err[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        issue_valid = v.iv;  issue_wr = v.iw;
        issue_rd = v.ird;    issue_rs1 = v.irs1; issue_rs2 = v.irs2;
        alu_valid = v.av;    alu_rd = v.ard;     alu_data = v.adata;
        mem_valid = v.mv;    mem_rd = v.mrd;     mem_data = v.mdata;
    endtask

    // Reference model state
    bit [31:0]   pend;
    bit          alu_first;
    bit          exp_rw, exp_err;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    function automatic logic [4:0] pick_rd();
        int q[$];
        for (int r = 1; r < 32; r++) if (pend[r]) q.push_back(r);
        if (q.size() > 0 && $urandom_range(7) != 0)
            return 5'(q[$urandom_range(q.size() - 1)]);
        return 5'($urandom_range(15));
    endfunction

    initial begin
        // iv iw ird rs1 rs2 | av ard adata | mv mrd mdata | st ar mr | rw wrd wdata err
        tbl[0]  = mk(1,1, 3,0,0, 0, 0,0,          0, 0,0,          0,0,0, 0, 0,0,          0);
        tbl[1]  = mk(1,1, 7,1,2, 1, 3,32'hDEAD,   0, 0,0,          0,1,0, 1, 3,32'hDEAD,   0);
        tbl[2]  = mk(1,0, 0,0,7, 0, 0,0,          0, 0,0,          1,0,0, 0, 3,32'hDEAD,   0);
        tbl[3]  = mk(1,1, 7,0,0, 0, 0,0,          0, 0,0,          1,0,0, 0, 3,32'hDEAD,   0);
        tbl[4]  = mk(1,1, 0,0,0, 0, 0,0,          0, 0,0,          0,0,0, 0, 3,32'hDEAD,   0);
        tbl[5]  = mk(1,0, 0,3,0, 0, 0,0,          1, 0,32'h1234,   0,0,1, 0, 3,32'hDEAD,   0);
        tbl[6]  = mk(1,1,10,0,0, 1, 7,32'h77,     1,10,32'h1010,   0,1,0, 1, 7,32'h77,     0);
        tbl[7]  = mk(1,1,11,0,0, 1,11,32'h1111,   1,10,32'h1010,   0,0,1, 1,10,32'h1010,   0);
        tbl[8]  = mk(1,1,12,0,0, 1,11,32'h1111,   1,12,32'h1212,   0,1,0, 1,11,32'h1111,   0);
        tbl[9]  = mk(0,0, 0,0,0, 1,12,32'hAAAA,   1,12,32'h1212,   0,0,1, 1,12,32'h1212,   0);
        tbl[10] = mk(0,0, 0,0,0, 1,12,32'hAAAA,   0, 0,0,          0,1,0, 1,12,32'hAAAA,   0);
        tbl[11] = mk(0,0, 0,0,0, 1, 9,32'h9999,   0, 0,0,          0,1,0, 1, 9,32'h9999,   1);
        tbl[12] = mk(0,0, 0,0,0, 0, 0,0,          0, 0,0,          0,0,0, 0, 9,32'h9999,   1);
        tbl[13] = mk(1,0, 0,9,0, 0, 0,0,          0, 0,0,          0,0,0, 0, 9,32'h9999,   1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_regWrite", {31'd0, regWrite}, 32'd0);
        chk("reset_wr_rd", {27'd0, wr_rd}, 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        chk("reset_wb_err", {31'd0, wb_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            #1;
            chk($sformatf("vec%0d_stall", i), {31'd0, issue_stall}, {31'd0, tbl[i].st});
            chk($sformatf("vec%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, tbl[i].ar});
            chk($sformatf("vec%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, tbl[i].mr});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_regWrite", i), {31'd0, regWrite}, {31'd0, tbl[i].rw});
            chk($sformatf("vec%0d_wr_rd", i), {27'd0, wr_rd}, {27'd0, tbl[i].wrd});
            chk($sformatf("vec%0d_wr_data", i), wr_data, tbl[i].wdata);
            chk($sformatf("vec%0d_wb_err", i), {31'd0, wb_err}, {31'd0, tbl[i].err});
        end

        // Reset in the middle of a write, with pending[5] set and wb_err sticky
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd5;
        issue_rs1 = '0; issue_rs2 = '0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
        #1;
        chk("rst_seq_alu_ready", {31'd0, alu_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_seq_regWrite_pre", {31'd0, regWrite}, 32'd1);
        chk("rst_seq_wr_rd_pre", {27'd0, wr_rd}, 32'd5);
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_wr = 1'b0; issue_rs1 = 5'd5;
        #1;
        chk("rst_seq_stall_pre", {31'd0, issue_stall}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_seq_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_seq_wr_rd", {27'd0, wr_rd}, 32'd0);
        chk("rst_seq_wr_data", wr_data, 32'd0);
        chk("rst_seq_wb_err", {31'd0, wb_err}, 32'd0);
        chk("rst_seq_stall", {31'd0, issue_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue_valid = 1'b0;

        // Randomized traffic against the model
        pend = '0; alu_first = 1'b1;
        exp_rw = 1'b0; exp_err = 1'b0; exp_rd = '0; exp_data = '0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit ga, gm, st, fire, xf;
            logic [4:0]  t_rd;
            logic [31:0] t_d;
            if (!alu_valid && $urandom_range(1) == 1) begin
                alu_valid = 1'b1; alu_rd = pick_rd(); alu_data = $urandom;
            end
            if (!mem_valid && $urandom_range(1) == 1) begin
                mem_valid = 1'b1; mem_rd = pick_rd(); mem_data = $urandom;
            end
            issue_valid = ($urandom_range(9) < 6);
            issue_wr    = $urandom_range(1) == 1;
            issue_rd    = 5'($urandom_range(15));
            issue_rs1   = 5'($urandom_range(15));
            issue_rs2   = 5'($urandom_range(15));
            #1;
            st = issue_valid && (pend[issue_rs1] || pend[issue_rs2] ||
                                 (issue_wr && pend[issue_rd]));
            if (alu_valid && mem_valid) begin
                ga = alu_first; gm = !alu_first;
            end else begin
                ga = alu_valid; gm = mem_valid;
            end
            chk("rand_stall", {31'd0, issue_stall}, {31'd0, st});
            chk("rand_alu_ready", {31'd0, alu_ready}, {31'd0, ga});
            chk("rand_mem_ready", {31'd0, mem_ready}, {31'd0, gm});

            fire = issue_valid && issue_wr && !st && (issue_rd != 0);
            xf   = ga || gm;
            t_rd = gm ? mem_rd : alu_rd;
            t_d  = gm ? mem_data : alu_data;
            if (xf && t_rd != 0 && !pend[t_rd]) exp_err = 1'b1;
            if (exp_rw) pend[exp_rd] = 1'b0;
            if (fire) pend[issue_rd] = 1'b1;
            if (xf && t_rd != 0) begin
                exp_rw = 1'b1; exp_rd = t_rd; exp_data = t_d;
            end else begin
                exp_rw = 1'b0;
            end
            if (ga) alu_first = 1'b0;
            else if (gm) alu_first = 1'b1;

            @(posedge clk); #1;
            chk("rand_regWrite", {31'd0, regWrite}, {31'd0, exp_rw});
            chk("rand_wr_rd", {27'd0, wr_rd}, {27'd0, exp_rd});
            chk("rand_wr_data", wr_data, exp_data);
            chk("rand_wb_err", {31'd0, wb_err}, {31'd0, exp_err});
            if (ga) alu_valid = 1'b0;
            if (gm) mem_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
